// File: rtl/seed_diff_pkg.sv
// Shared types and constants for the seed differencing block.
package seed_diff_pkg;

    localparam int SEED_W = 16;
    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/seed_fifo2.sv
// Two-entry FIFO with a registered head; tolerates push and pop on the same edge.
module seed_fifo2 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [1:0]       cnt;
    logic [WIDTH-1:0] tail;

    assign full  = (cnt == 2'(DEPTH));
    assign empty = (cnt == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: if (!full) begin
                    if (empty) head <= din;
                    else       tail <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: if (!empty) begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Pop of an empty FIFO is meaningless, so the push alone lands
                    if (empty) begin
                        head <= din;
                        cnt  <= 2'd1;
                    end else if (cnt == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seed_diff.sv
// Recovers per-step increments from an accumulated seed stream by differencing
// consecutive samples against a reference established by a sync sample.
module seed_diff
    import seed_diff_pkg::*;
#(
    parameter int WIDTH = SEED_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_z,
    input  logic             in_sync,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_nseed,
    output logic [15:0]      out_cnt,
    output logic [7:0]       drop_cnt
);

    state_t           state;
    logic [WIDTH-1:0] ref_z;
    logic             full, empty;
    logic             accept, push, pop;
    logic [WIDTH-1:0] diff;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign push      = accept && !in_sync && (state == RUN);
    assign diff      = in_z - ref_z;

    seed_fifo2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (diff),
        .full  (full),
        .empty (empty),
        .head  (out_nseed)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ref_z    <= '0;
            drop_cnt <= 8'd0;
        end else if (accept) begin
            if (in_sync) begin
                ref_z <= in_z;
                state <= RUN;
            end else if (state == RUN) begin
                ref_z <= in_z;
            end else if (drop_cnt != DROP_MAX) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      out_cnt <= 16'd0;
        else if (pop) out_cnt <= out_cnt + 16'd1;
    end

endmodule
